// File: rtl/mips_data_mem_responder.sv
// mips_data_mem_responder
//   Memory-side responder for the MIPS data port. Accepts one load/store
//   request per handshake, waits WAIT_STATES cycles, performs the RAM access
//   on the edge that enters RESP, then holds the response until consumed.
//
// Parameters:
//   DATA_WIDTH   - data word width
//   MEMORY_DEPTH - number of words (power of two, >= 4)
//   WAIT_STATES  - extra cycles between accept and response (0..15)
//
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   in_ReqValid       - request present        o_ReqReady - can accept (IDLE)
//   in_MemRead        - load                   in_MemWrite - store
//   in_Address_dw     - byte address           in_WriteData_dw - store data
//   o_RespValid       - response present       in_RespReady - response consumed
//   o_ReadData_dw     - load data (0 for stores / no-ops)
//   o_Busy            - high whenever not IDLE
//   o_Error           - misaligned access flag (MEM_ALIGN_CHECK_EN only)
//
// Build option: define MEM_ALIGN_CHECK_EN to flag accesses with address[1:0]!=0;
// such a store is suppressed and load data is forced to 0.
module mips_data_mem_responder #(
  parameter int DATA_WIDTH   = 32,
  parameter int MEMORY_DEPTH = 256,
  parameter int WAIT_STATES  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_ReqValid,
  output logic                  o_ReqReady,
  input  logic                  in_MemRead,
  input  logic                  in_MemWrite,
  input  logic [31:0]           in_Address_dw,
  input  logic [DATA_WIDTH-1:0] in_WriteData_dw,
  output logic                  o_RespValid,
  input  logic                  in_RespReady,
  output logic [DATA_WIDTH-1:0] o_ReadData_dw,
  output logic                  o_Busy
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic                  o_Error
`endif
);

  localparam int AW = $clog2(MEMORY_DEPTH);
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [AW+1:0]         addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  // Access operands: straight from the request when entering RESP directly
  // from IDLE (WAIT_STATES==0), otherwise from the latched copy.
  logic                  from_req;
  logic [AW+1:0]         acc_addr;
  logic [AW-1:0]         acc_idx;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  acc_rd, acc_wr;
  logic                  misaligned;
  logic                  access;
  logic                  mem_we;
  logic                  unused_ok;

  assign from_req  = (state_q == S_IDLE);
  assign acc_addr  = from_req ? in_Address_dw[AW+1:0] : addr_q;
  assign acc_wdata = from_req ? in_WriteData_dw : wdata_q;
  assign acc_rd    = from_req ? in_MemRead : rd_q;
  assign acc_wr    = from_req ? in_MemWrite : wr_q;
  assign acc_idx   = acc_addr[AW+1:2];
  assign unused_ok = ^{in_Address_dw[31:AW+2], acc_addr[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = |acc_addr[1:0];
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    access  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_ReqValid) begin
          addr_d  = in_Address_dw[AW+1:0];
          wdata_d = in_WriteData_dw;
          rd_d    = in_MemRead;
          wr_d    = in_MemWrite;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = S_RESP;
            access  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (in_RespReady) begin
          state_d = S_IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Read-before-write: the response register captures the old word even
    // when the same access also stores.
    if (access) begin
      rdata_d = (acc_rd && !misaligned) ? mem[acc_idx] : '0;
      err_d   = misaligned;
    end
  end

  assign mem_we = access && acc_wr && !misaligned;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    rd_q    <= rd_d;
    wr_q    <= wr_d;
  end

  // RAM is not reset; a reset on the access edge discards the store.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  assign o_ReqReady    = (state_q == S_IDLE);
  assign o_RespValid   = (state_q == S_RESP);
  assign o_Busy        = (state_q != S_IDLE);
  assign o_ReadData_dw = rdata_q;
`ifdef MEM_ALIGN_CHECK_EN
  assign o_Error       = err_q;
`endif

endmodule

// File: tb/tb_mips_data_mem_responder.sv
// Scoreboard bench for mips_data_mem_responder (DATA_WIDTH=32,
// MEMORY_DEPTH=256, WAIT_STATES=2). Stimulus pushes expected responses;
// a negedge monitor compares them against every response cycle.
module tb_mips_data_mem_responder;

  localparam int WS = 2;

  logic        clk;
  logic        reset;
  logic        in_ReqValid;
  logic        o_ReqReady;
  logic        in_MemRead;
  logic        in_MemWrite;
  logic [31:0] in_Address_dw;
  logic [31:0] in_WriteData_dw;
  logic        o_RespValid;
  logic        in_RespReady;
  logic [31:0] o_ReadData_dw;
  logic        o_Busy;
  logic        o_Error;

  mips_data_mem_responder #(
    .DATA_WIDTH(32),
    .MEMORY_DEPTH(256),
    .WAIT_STATES(WS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_ReqValid(in_ReqValid),
    .o_ReqReady(o_ReqReady),
    .in_MemRead(in_MemRead),
    .in_MemWrite(in_MemWrite),
    .in_Address_dw(in_Address_dw),
    .in_WriteData_dw(in_WriteData_dw),
    .o_RespValid(o_RespValid),
    .in_RespReady(in_RespReady),
    .o_ReadData_dw(o_ReadData_dw),
    .o_Busy(o_Busy)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .o_Error(o_Error)
`endif
  );

`ifndef MEM_ALIGN_CHECK_EN
  assign o_Error = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   resp_done = 0;
  int   exp_done = 0;
  bit   prev_hs = 0;
  bit   prev_valid = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every response cycle against the scoreboard head.
  always @(negedge clk) begin
    if (reset) begin
      prev_hs    = 0;
      prev_valid = 0;
    end else begin
      if (prev_hs) begin
        chk("req_ready_after_resp", {31'd0, o_ReqReady}, 32'd1);
        chk("resp_valid_dropped", {31'd0, o_RespValid}, 32'd0);
      end
      if (o_RespValid) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          if (!prev_valid) chk("resp_latency", cyc, sb[0].cyc);
          chk("resp_data", o_ReadData_dw, sb[0].data);
`ifdef MEM_ALIGN_CHECK_EN
          chk("resp_error", {31'd0, o_Error}, {31'd0, sb[0].err});
`endif
          chk("req_ready_in_resp", {31'd0, o_ReqReady}, 32'd0);
          chk("busy_in_resp", {31'd0, o_Busy}, 32'd1);
          if (in_RespReady) begin
            void'(sb.pop_front());
            resp_done++;
          end
        end
      end
      prev_hs    = o_RespValid && in_RespReady;
      prev_valid = o_RespValid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp();
    int g = 0;
    while (resp_done < exp_done && g < 200) begin
      step();
      g++;
    end
    if (resp_done < exp_done) chk("resp_timeout", resp_done, exp_done);
  endtask

  // Issue one request; called one delta after a rising edge.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_data,
                       input logic exp_err, input bit push, input bit wait_done);
    int g = 0;
    while (!o_ReqReady && g < 100) begin
      step();
      g++;
    end
    if (!o_ReqReady) begin
      chk("req_ready_timeout", 32'd0, 32'd1);
    end else begin
      in_ReqValid     = 1'b1;
      in_MemRead      = rd;
      in_MemWrite     = wr;
      in_Address_dw   = addr;
      in_WriteData_dw = wdata;
      if (push) begin
        sb.push_back('{exp_data, exp_err, cyc + 1 + WS});
        exp_done++;
      end
      step();
      in_ReqValid = 1'b0;
      in_MemRead  = 1'b0;
      in_MemWrite = 1'b0;
      if (wait_done) wait_resp();
    end
  endtask

  initial begin
    int g;
    reset           = 1'b1;
    in_ReqValid     = 1'b0;
    in_MemRead      = 1'b0;
    in_MemWrite     = 1'b0;
    in_Address_dw   = 32'd0;
    in_WriteData_dw = 32'd0;
    in_RespReady    = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Reset / idle state
    chk("reset_req_ready", {31'd0, o_ReqReady}, 32'd1);
    chk("reset_resp_valid", {31'd0, o_RespValid}, 32'd0);
    chk("reset_read_data", o_ReadData_dw, 32'd0);
    chk("reset_busy", {31'd0, o_Busy}, 32'd0);
    chk("reset_error", {31'd0, o_Error}, 32'd0);

    // Known contents for locations read later
    issue(0, 1, 32'h20, 32'h0, 32'h0, 0, 1, 1);
    issue(0, 1, 32'h30, 32'h11111111, 32'h0, 0, 1, 1);

    // Store then load, fixed latency checked by the monitor
    issue(0, 1, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1, 1);
    issue(1, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1, 1);

    // Address wrap modulo MEMORY_DEPTH*4
    issue(0, 1, 32'h404, 32'h12345678, 32'h0, 0, 1, 1);
    issue(1, 0, 32'h004, 32'h0, 32'h12345678, 0, 1, 1);

    // No-op returns 0 and leaves RAM alone
    issue(0, 0, 32'h10, 32'hFFFFFFFF, 32'h0, 0, 1, 1);
    // Load+store: old data returned, store performed
    issue(1, 1, 32'h10, 32'hA5A5A5A5, 32'hDEADBEEF, 0, 1, 1);
    issue(1, 0, 32'h10, 32'h0, 32'hA5A5A5A5, 0, 1, 1);

    // Unaligned load of word 4
`ifdef MEM_ALIGN_CHECK_EN
    issue(1, 0, 32'h13, 32'h0, 32'h0, 1, 1, 1);
`else
    issue(1, 0, 32'h13, 32'h0, 32'hA5A5A5A5, 0, 1, 1);
`endif

    // Backpressure: response held 4+ cycles while a new request is ignored
    in_RespReady = 1'b0;
    issue(1, 0, 32'h004, 32'h0, 32'h12345678, 0, 1, 0);
    g = 0;
    while (!o_RespValid && g < 50) begin
      step();
      g++;
    end
    chk("bp_resp_seen", {31'd0, o_RespValid}, 32'd1);
    in_ReqValid     = 1'b1;
    in_MemWrite     = 1'b1;
    in_Address_dw   = 32'h30;
    in_WriteData_dw = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_req_ready_low", {31'd0, o_ReqReady}, 32'd0);
      chk("bp_resp_valid_held", {31'd0, o_RespValid}, 32'd1);
    end
    in_ReqValid  = 1'b0;
    in_MemWrite  = 1'b0;
    in_RespReady = 1'b1;
    wait_resp();
    issue(1, 0, 32'h30, 32'h0, 32'h11111111, 0, 1, 1);

    // Reset while in WAIT discards the store
    issue(0, 1, 32'h20, 32'hCAFEF00D, 32'h0, 0, 0, 0);
    chk("mid_wait_busy", {31'd0, o_Busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("post_reset_busy", {31'd0, o_Busy}, 32'd0);
    chk("post_reset_req_ready", {31'd0, o_ReqReady}, 32'd1);
    step();
    chk("post_reset_still_idle", {31'd0, o_RespValid}, 32'd0);
    issue(1, 0, 32'h20, 32'h0, 32'h0, 0, 1, 1);

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned store suppressed and flagged
    issue(0, 1, 32'h22, 32'h1, 32'h0, 1, 1, 1);
    issue(1, 0, 32'h20, 32'h0, 32'h0, 0, 1, 1);
`endif

    step();
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
